// File: rtl/triangle_assemble.sv
// Groups a flat vertex stream into triangles and buffers them in a DEPTH-entry FIFO.
// Optional statistics counters are enabled with TRIANGLE_ASSEMBLE_STATS_EN.
module triangle_assemble #(
    parameter int unsigned DEPTH = 4
) (
    input  logic                    clk_in,
    input  logic                    rst_in,
    input  logic                    flush_in,
    input  logic                    valid_in,
    input  logic [3:0][31:0]        vertex_in,
    output logic                    valid_out,
    input  logic                    ready_in,
    output logic [2:0][3:0][31:0]   triangle_out,
    output logic [$clog2(DEPTH):0]  count_out,
    output logic                    overflow_out
`ifdef TRIANGLE_ASSEMBLE_STATS_EN
    ,
    output logic [31:0]             accepted_count_out,
    output logic [31:0]             dropped_count_out
`endif
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;
    localparam logic [CW-1:0] Full = CW'(DEPTH);

    typedef enum logic [1:0] {V0, V1, V2} vidx_e;

    vidx_e              vidx_q, vidx_d;
    logic [3:0][31:0]   slot0_q, slot0_d;
    logic [3:0][31:0]   slot1_q, slot1_d;
    logic [PW-1:0]      wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]      rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]      count_q, count_d;
    logic               overflow_q, overflow_d;
    logic [2:0][3:0][31:0] mem_q [DEPTH];

    logic pop;
    logic tri_done;
    logic has_space;
    logic push;
    logic drop;

    // Flush masks every event in its cycle.
    assign pop       = (count_q != '0) && ready_in && !flush_in;
    assign tri_done  = valid_in && (vidx_q == V2) && !flush_in;
    assign has_space = (count_q != Full) || pop;
    assign push      = tri_done && has_space;
    assign drop      = tri_done && !has_space;

    always_comb begin
        vidx_d     = vidx_q;
        slot0_d    = slot0_q;
        slot1_d    = slot1_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        overflow_d = overflow_q || drop;

        if (flush_in) begin
            vidx_d   = V0;
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (valid_in) begin
                unique case (vidx_q)
                    V0: begin
                        slot0_d = vertex_in;
                        vidx_d  = V1;
                    end
                    V1: begin
                        slot1_d = vertex_in;
                        vidx_d  = V2;
                    end
                    default: vidx_d = V0;
                endcase
            end
            if (push) wr_ptr_d = wr_ptr_q + PW'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
            if (push && !pop)      count_d = count_q + CW'(1);
            else if (pop && !push) count_d = count_q - CW'(1);
        end
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            vidx_q     <= V0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            vidx_q     <= vidx_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

    // Payload storage carries no reset.
    always_ff @(posedge clk_in) begin
        slot0_q <= slot0_d;
        slot1_q <= slot1_d;
        if (push) mem_q[wr_ptr_q] <= {vertex_in, slot1_q, slot0_q};
    end

    assign valid_out    = (count_q != '0);
    assign count_out    = count_q;
    assign overflow_out = overflow_q;
    assign triangle_out = mem_q[rd_ptr_q];

`ifdef TRIANGLE_ASSEMBLE_STATS_EN
    logic [31:0] accepted_q, accepted_d;
    logic [31:0] dropped_q, dropped_d;

    always_comb begin
        accepted_d = accepted_q + {31'd0, push};
        dropped_d  = dropped_q + {31'd0, drop};
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            accepted_q <= '0;
            dropped_q  <= '0;
        end else begin
            accepted_q <= accepted_d;
            dropped_q  <= dropped_d;
        end
    end

    assign accepted_count_out = accepted_q;
    assign dropped_count_out  = dropped_q;
`endif

endmodule

// File: tb/tb_triangle_assemble.sv
// Self-checking bench for triangle_assemble: directed scenarios plus a randomized phase,
// all compared against a queue-based reference model.
module tb_triangle_assemble;

    localparam int unsigned DEPTH = 4;

    logic                   clk_in = 1'b0;
    logic                   rst_in;
    logic                   flush_in;
    logic                   valid_in;
    logic [3:0][31:0]       vertex_in;
    logic                   valid_out;
    logic                   ready_in;
    logic [2:0][3:0][31:0]  triangle_out;
    logic [$clog2(DEPTH):0] count_out;
    logic                   overflow_out;
`ifdef TRIANGLE_ASSEMBLE_STATS_EN
    logic [31:0]            accepted_count_out;
    logic [31:0]            dropped_count_out;
`endif

    triangle_assemble #(.DEPTH(DEPTH)) dut (
        .clk_in       (clk_in),
        .rst_in       (rst_in),
        .flush_in     (flush_in),
        .valid_in     (valid_in),
        .vertex_in    (vertex_in),
        .valid_out    (valid_out),
        .ready_in     (ready_in),
        .triangle_out (triangle_out),
        .count_out    (count_out),
        .overflow_out (overflow_out)
`ifdef TRIANGLE_ASSEMBLE_STATS_EN
        ,
        .accepted_count_out (accepted_count_out),
        .dropped_count_out  (dropped_count_out)
`endif
    );

    always #5 clk_in = ~clk_in;

    // Reference model: pending vertices, buffered triangles, sticky flag, stats.
    logic [127:0] pend [$];
    logic [383:0] fifo [$];
    bit           m_ovf;
    int unsigned  m_acc;
    int unsigned  m_drop;

    int tests = 0;
    int fails = 0;

    task automatic chk(input string tag, input logic [383:0] obs, input logic [383:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        chk("valid_out", {383'd0, valid_out}, {383'd0, fifo.size() != 0});
        chk("count_out", {381'd0, count_out}, 384'(fifo.size()));
        chk("overflow_out", {383'd0, overflow_out}, {383'd0, m_ovf});
        if (fifo.size() != 0) chk("triangle_out", triangle_out, fifo[0]);
`ifdef TRIANGLE_ASSEMBLE_STATS_EN
        chk("accepted_count", {352'd0, accepted_count_out}, 384'(m_acc));
        chk("dropped_count", {352'd0, dropped_count_out}, 384'(m_drop));
`endif
    endtask

    task automatic model_reset();
        pend.delete();
        fifo.delete();
        m_ovf  = 0;
        m_acc  = 0;
        m_drop = 0;
    endtask

    task automatic step(input bit v, input logic [127:0] vx, input bit rdy, input bit fl);
        logic [383:0] t;
        valid_in  = v;
        vertex_in = vx;
        ready_in  = rdy;
        flush_in  = fl;
        @(posedge clk_in);
        if (fl) begin
            pend.delete();
            fifo.delete();
        end else begin
            if (rdy && fifo.size() != 0) void'(fifo.pop_front());
            if (v) begin
                pend.push_back(vx);
                if (pend.size() == 3) begin
                    t = {pend[2], pend[1], pend[0]};
                    pend.delete();
                    if (fifo.size() < DEPTH) begin
                        fifo.push_back(t);
                        m_acc++;
                    end else begin
                        m_ovf = 1;
                        m_drop++;
                    end
                end
            end
        end
        #1;
        valid_in = 1'b0;
        ready_in = 1'b0;
        flush_in = 1'b0;
        check_all();
    endtask

    task automatic do_reset();
        rst_in = 1'b0;
        #1;
        model_reset();
        check_all();
        @(negedge clk_in);
        @(negedge clk_in);
        rst_in = 1'b1;
    endtask

    function automatic logic [127:0] rnd_vtx();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    logic [127:0] va, vb, vc;

    initial begin
        va = {32'h3F800000, 32'h3F687FCC, 32'h3E5C28F6, 32'h3F25E354};
        vb = {32'h3F800000, 32'hBDF3B646, 32'h3F7B22D1, 32'hBEFEF9DB};
        vc = {32'h3F800000, 32'h3F7F837B, 32'hBE6147AE, 32'h3EFB7E91};
        valid_in  = 1'b0;
        vertex_in = '0;
        ready_in  = 1'b0;
        flush_in  = 1'b0;
        model_reset();
        do_reset();

        // Single triangle, then pop.
        step(1, va, 0, 0);
        step(1, vb, 0, 0);
        step(1, vc, 0, 0);
        chk("single_tri_exact", triangle_out, {vc, vb, va});
        step(0, '0, 1, 0);

        // Gapped input.
        step(1, va, 0, 0);
        step(0, '0, 0, 0);
        step(1, vb, 0, 0);
        step(1, vc, 0, 0);
        chk("gapped_tri_exact", triangle_out, {vc, vb, va});
        step(0, '0, 1, 0);

        // Overflow: five triangles with no pops, then drain.
        for (int i = 0; i < 15; i++) step(1, rnd_vtx(), 0, 0);
        chk("ovf_count", {381'd0, count_out}, 384'(DEPTH));
        chk("ovf_flag", {383'd0, overflow_out}, 384'd1);
        for (int i = 0; i < 5; i++) step(0, '0, 1, 0);

        // Full with a simultaneous pop: no drop.
        do_reset();
        for (int i = 0; i < 14; i++) step(1, rnd_vtx(), 0, 0);
        step(1, vc, 1, 0);
        chk("full_pop_count", {381'd0, count_out}, 384'(DEPTH));
        chk("full_pop_ovf", {383'd0, overflow_out}, 384'd0);
        for (int i = 0; i < 5; i++) step(0, '0, 1, 0);

        // Flush with a coincident vertex.
        step(1, rnd_vtx(), 0, 0);
        step(1, rnd_vtx(), 0, 0);
        step(1, rnd_vtx(), 0, 1);
        chk("flush_empty", {381'd0, count_out}, 384'd0);
        step(1, va, 0, 0);
        step(1, vb, 0, 0);
        step(1, vc, 0, 0);
        chk("flush_tri", triangle_out, {vc, vb, va});
        step(0, '0, 1, 0);

        // Async reset mid-triangle with a triangle buffered.
        step(1, rnd_vtx(), 0, 0);
        step(1, rnd_vtx(), 0, 0);
        step(1, rnd_vtx(), 0, 0);
        step(1, rnd_vtx(), 0, 0);
        do_reset();
        step(1, va, 0, 0);
        step(1, vb, 0, 0);
        step(1, vc, 0, 0);
        chk("post_reset_tri", triangle_out, {vc, vb, va});

        // Randomized traffic.
        for (int i = 0; i < 400; i++) begin
            step($urandom_range(0, 9) < 7, rnd_vtx(), $urandom_range(0, 9) < 3,
                 $urandom_range(0, 49) == 0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/triangle_assemble.md
# triangle_assemble

Groups the flat vertex stream produced by `triangle_clip` into whole triangles and buffers them for the rasterizer setup stage. The clip stage has no backpressure, so this block absorbs bursts in a DEPTH-entry triangle FIFO, presents one triangle at a time with a valid/ready handshake, and drops whole triangles (never partial ones) on overflow.

## Interface
- `DEPTH`, 4: FIFO capacity in triangles; power of two, ≥ 2.
- `clk_in`  input  1  system clock; all state updates on rising edge.
- `rst_in`  input  1  reset, asynchronous, active-low.
- `flush_in`  input  1  synchronous flush: discards the partial triangle and all FIFO contents.
- `valid_in`  input  1  `vertex_in` carries a vertex this cycle.
- `vertex_in`  input  [3:0][31:0]  fp32 `{w, z, y, x}`, passed through untouched.
- `valid_out`  output  1  `triangle_out` holds a buffered triangle.
- `ready_in`  input  1  downstream accepts `triangle_out` this cycle.
- `triangle_out`  output  [2:0][3:0][31:0]  head triangle; `[0]` is the first vertex received.
- `count_out`  output  $clog2(DEPTH)+1  triangles currently buffered.
- `overflow_out`  output  1  sticky; set when a triangle is dropped.

## Operation
- Vertex counter `vidx` ∈ {0,1,2}. States: V0, V1, V2.
  - V0/V1 with `valid_in`: store the vertex in staging slot 0/1, advance.
  - V2 with `valid_in`: form `{vertex_in, slot1, slot0}`. If space is available, push it; otherwise drop it and set `overflow_out`. Return to V0 in either case.
- Space is available when `count_out < DEPTH`, or when `count_out == DEPTH` and a pop occurs in the same cycle.
- Pop: `valid_out && ready_in`. Advances the read pointer.
- Push and pop in the same cycle leave `count_out` unchanged.
- Pointers are `$clog2(DEPTH)` bits and wrap naturally. Full and empty are derived from `count_out`, not from pointer equality.
- `valid_out = (count_out != 0)`. `triangle_out` is the memory entry at the read pointer. When empty, `triangle_out` is don't-care.
- `flush_in` has priority over all other events in its cycle:
  - `vidx` ← 0; `count_out` ← 0; pointers ← 0.
  - Any `valid_in` vertex and any pop that cycle are ignored.
  - `overflow_out` is not cleared.
- `valid_in` has no handshake: every asserted cycle consumes one vertex.
- The fp32 payload is opaque. NaN and Inf pass through bit-exact.

## Timing
- Reset (async assert, sync deassert by the system) drives:
  - `valid_out` = 0, `count_out` = 0, `overflow_out` = 0;
  - `vidx` = V0; pointers = 0; statistics counters = 0.
  - Staging and memory contents are not reset.
- Reset mid-triangle discards the partial triangle. The next vertex after reset is vertex 0.
- Latency: the third vertex is sampled at edge N; `valid_out` = 1 and `triangle_out` is valid after edge N (visible in cycle N+1).
- After a pop at edge M, the next entry appears after edge M. Back-to-back pops sustain one triangle per cycle.
- Throughput: vertices are accepted on consecutive cycles without stall. Gaps in `valid_in` do not reset `vidx`.
- `overflow_out` rises on the edge where the dropped third vertex is sampled.

## Configuration
- `TRIANGLE_ASSEMBLE_STATS_EN` defined:
  - adds `accepted_count_out` (output, 32 bits), incremented per pushed triangle;
  - adds `dropped_count_out` (output, 32 bits), incremented per dropped triangle;
  - both wrap at 2^32, reset to 0, and are unaffected by `flush_in`.
- Not defined: both ports and their counters are absent. All other behaviour is identical.

## Test plan
- Single triangle: vertices `{3F800000,3F687FCC,3E5C28F6,3F25E354}`, `{3F800000,BDF3B646,3F7B22D1,BEFEF9DB}`, `{3F800000,3F7F837B,BE6147AE,3EFB7E91}` on consecutive cycles, `ready_in` = 0. Required: `valid_out` = 1 and `count_out` = 1 one cycle after the third vertex, with `triangle_out[0..2]` bit-exact to the inputs in arrival order. Then `ready_in` = 1 for one cycle → `count_out` = 0, `valid_out` = 0.
- Gapped input: the same three vertices with `valid_in` low for one cycle between vertex 1 and vertex 2. Required: one triangle with identical content.
- Overflow (DEPTH = 4): 5 triangles (15 vertices) with `ready_in` = 0. Required:
  - `count_out` = 4, `overflow_out` = 1 after vertex 15;
  - the first 4 triangles pop out in order;
  - with the stats macro: `accepted_count_out` = 4, `dropped_count_out` = 1.
- Full with simultaneous pop: FIFO full, `ready_in` = 1 on the cycle the 5th triangle completes. Required: no drop, `count_out` stays 4, `overflow_out` stays 0, the 5th triangle comes out last.
- Flush: 2 vertices, then `flush_in` = 1 with `valid_in` = 1, then 3 vertices. Required: exactly one triangle, made of the last 3 vertices; the FIFO was empty after the flush.
- Async reset mid-triangle: assert `rst_in` low between edges after 1 vertex. Required: all outputs go to their reset values immediately. After release, 3 vertices produce one triangle starting from the first post-reset vertex.
